// File: rtl/pipe_stage_elastic.sv
// Elastic valid/ready stage register with a 2-entry skid buffer.
// Adds synchronous flush, bubble outputs and a saturating stall counter.
module pipe_stage_elastic #(
  parameter int unsigned          DATA_W   = 128,
  parameter int unsigned          CTRL_W   = 5,
  parameter int unsigned          STAT_W   = 4,
  parameter logic [STAT_W-1:0]    STAT_RST = 4'b1110,
  parameter int unsigned          CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic [STAT_W-1:0] in_stat,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [STAT_W-1:0] out_stat,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state_q;
  logic [CTRL_W-1:0] h_ctrl_q, k_ctrl_q;
  logic [DATA_W-1:0] h_data_q, k_data_q;
  logic [STAT_W-1:0] h_stat_q, k_stat_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              in_fire, out_fire;

  // Handshake flags come from registered state only.
  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  assign out_ctrl  = h_ctrl_q;
  assign out_data  = h_data_q;
  assign out_stat  = h_stat_q;
  assign occupancy = state_q;
  assign stall_cnt = cnt_q;

  // State, head and skid registers; a vacated slot reloads the bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= EMPTY;
      h_ctrl_q <= '0;
      h_data_q <= '0;
      h_stat_q <= STAT_RST;
      k_ctrl_q <= '0;
      k_data_q <= '0;
      k_stat_q <= STAT_RST;
    end else if (flush) begin
      state_q  <= EMPTY;
      h_ctrl_q <= '0;
      h_data_q <= '0;
      h_stat_q <= STAT_RST;
      k_ctrl_q <= '0;
      k_data_q <= '0;
      k_stat_q <= STAT_RST;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_q  <= ONE;
            h_ctrl_q <= in_ctrl;
            h_data_q <= in_data;
            h_stat_q <= in_stat;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            h_ctrl_q <= in_ctrl;
            h_data_q <= in_data;
            h_stat_q <= in_stat;
          end else if (out_fire) begin
            state_q  <= EMPTY;
            h_ctrl_q <= '0;
            h_data_q <= '0;
            h_stat_q <= STAT_RST;
          end else if (in_fire) begin
            state_q  <= FULL;
            k_ctrl_q <= in_ctrl;
            k_data_q <= in_data;
            k_stat_q <= in_stat;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_q  <= ONE;
            h_ctrl_q <= k_ctrl_q;
            h_data_q <= k_data_q;
            h_stat_q <= k_stat_q;
            k_ctrl_q <= '0;
            k_data_q <= '0;
            k_stat_q <= STAT_RST;
          end
        end
        default: begin
          state_q <= EMPTY;
        end
      endcase
    end
  end

  // Saturating count of cycles the head waits on downstream.
  always_comb begin
    cnt_d = cnt_q;
    if (out_valid && !out_ready && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + 1'b1;
  end

  // Stall counter survives flush; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: queue model, directed cases, random run.
// A second instance with a 4-bit counter covers stall saturation.
module tb_pipe_stage_elastic;

  typedef struct packed {
    logic [4:0]   c;
    logic [127:0] d;
    logic [3:0]   s;
  } ent_t;

  logic         clk = 0;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic         in_ready, in_ready2;
  logic [4:0]   in_ctrl;
  logic [127:0] in_data;
  logic [3:0]   in_stat;
  logic         out_valid, out_valid2;
  logic         out_ready;
  logic [4:0]   out_ctrl, out_ctrl2;
  logic [127:0] out_data, out_data2;
  logic [3:0]   out_stat, out_stat2;
  logic [1:0]   occupancy, occupancy2;
  logic [15:0]  stall_cnt;
  logic [3:0]   stall_cnt2;

  int checks = 0;
  int errors = 0;

  ent_t        q[$];
  int unsigned mcnt;

  always #5 clk = ~clk;

  pipe_stage_elastic dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .in_stat(in_stat),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_data(out_data), .out_stat(out_stat),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  pipe_stage_elastic #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready2),
    .in_ctrl(in_ctrl), .in_data(in_data), .in_stat(in_stat),
    .out_valid(out_valid2), .out_ready(out_ready),
    .out_ctrl(out_ctrl2), .out_data(out_data2), .out_stat(out_stat2),
    .occupancy(occupancy2), .stall_cnt(stall_cnt2)
  );

  task automatic chk(input string n, input logic [159:0] a,
                     input logic [159:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", n, a, e);
    end
  endtask

  task automatic compare_all();
    ent_t e;
    int unsigned c16, c4;
    e = '{c: 5'd0, d: 128'd0, s: 4'b1110};
    if (q.size() > 0) e = q[0];
    c16 = (mcnt > 65535) ? 65535 : mcnt;
    c4  = (mcnt > 15) ? 15 : mcnt;
    chk("out_valid", 160'(out_valid), 160'(q.size() != 0));
    chk("in_ready", 160'(in_ready), 160'(q.size() != 2));
    chk("occupancy", 160'(occupancy), 160'(q.size()));
    chk("out_ctrl", 160'(out_ctrl), 160'(e.c));
    chk("out_data", 160'(out_data), 160'(e.d));
    chk("out_stat", 160'(out_stat), 160'(e.s));
    chk("stall_cnt", 160'(stall_cnt), 160'(c16));
    chk("stall_cnt4", 160'(stall_cnt2), 160'(c4));
    chk("out_data4", 160'(out_data2), 160'(e.d));
  endtask

  // One clock of stimulus: drive, advance model, compare at negedge.
  task automatic step(input logic iv, input ent_t e,
                      input logic ordy, input logic fl);
    bit inf, outf;
    in_valid  = iv;
    in_ctrl   = e.c;
    in_data   = e.d;
    in_stat   = e.s;
    out_ready = ordy;
    flush     = fl;
    inf  = iv && (q.size() < 2);
    outf = (q.size() > 0) && ordy;
    if (q.size() > 0 && !ordy) mcnt++;
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (outf) void'(q.pop_front());
      if (inf) q.push_back(e);
    end
    @(negedge clk);
    compare_all();
  endtask

  function automatic ent_t mk(input int unsigned v);
    ent_t e;
    e.c = 5'(v) | 5'd1;
    e.d = 128'(v);
    e.s = 4'(v);
    return e;
  endfunction

  function automatic ent_t rnd();
    ent_t e;
    e.c = 5'($urandom);
    e.d = {$urandom, $urandom, $urandom, $urandom};
    e.s = 4'($urandom);
    return e;
  endfunction

  task automatic do_reset();
    rst = 1;
    q.delete();
    mcnt = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    compare_all();
  endtask

  ent_t z;

  initial begin
    z = '0;
    rst = 1; flush = 0; in_valid = 0; out_ready = 0;
    in_ctrl = 0; in_data = 0; in_stat = 0;
    q.delete();
    mcnt = 0;
    @(negedge clk);
    do_reset();
    chk("rst_stat_lit", 160'(out_stat), 160'(4'b1110));
    chk("rst_ready_lit", 160'(in_ready), 160'(1));

    // Streaming 1..8 with one-cycle lag.
    for (int i = 1; i <= 8; i++) begin
      step(1, mk(i), 1, 0);
      chk("stream_lit", 160'(out_data), 160'(i));
    end
    step(0, z, 1, 0);
    chk("stream_stall_lit", 160'(stall_cnt), 160'(0));
    chk("stream_empty_lit", 160'(out_valid), 160'(0));

    // Skid: A, B with downstream stalled three cycles.
    step(1, mk(32'hA), 0, 0);
    step(1, mk(32'hB), 0, 0);
    step(0, z, 0, 0);
    step(1, mk(32'hC), 0, 0);
    chk("skid_occ_lit", 160'(occupancy), 160'(2));
    chk("skid_rdy_lit", 160'(in_ready), 160'(0));
    chk("skid_head_lit", 160'(out_data), 160'(32'hA));
    chk("skid_stall_lit", 160'(stall_cnt), 160'(3));
    step(1, mk(32'hC), 1, 0);
    chk("skid_b_lit", 160'(out_data), 160'(32'hB));
    chk("skid_occ1_lit", 160'(occupancy), 160'(1));
    step(1, mk(32'hC), 1, 0);
    chk("both_fire_lit", 160'(out_data), 160'(32'hC));
    chk("both_occ_lit", 160'(occupancy), 160'(1));
    step(0, z, 1, 0);

    // Flush while full with a new input offered.
    step(1, mk(32'h11), 0, 0);
    step(1, mk(32'h12), 0, 0);
    step(1, mk(32'hD), 0, 1);
    chk("flush_valid_lit", 160'(out_valid), 160'(0));
    chk("flush_ctrl_lit", 160'(out_ctrl), 160'(0));
    chk("flush_stat_lit", 160'(out_stat), 160'(4'b1110));
    chk("flush_occ_lit", 160'(occupancy), 160'(0));
    chk("flush_cnt_lit", 160'(stall_cnt), 160'(5));
    for (int i = 0; i < 3; i++) begin
      step(0, z, 1, 0);
      chk("flush_noD_lit", 160'(out_valid), 160'(0));
    end

    // Saturation of the 4-bit counter.
    step(1, mk(32'h5A), 0, 0);
    for (int i = 0; i < 20; i++) step(0, z, 0, 0);
    chk("sat_lit", 160'(stall_cnt2), 160'(15));
    chk("nosat_lit", 160'(stall_cnt), 160'(25));

    // Random traffic with a mid-stream async reset.
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 3) != 0), rnd(),
           1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 39) == 0));
      if (i == 1500) begin
        step(1, rnd(), 0, 0);
        step(1, rnd(), 0, 0);
        #2 rst = 1;
        q.delete();
        mcnt = 0;
        #1 compare_all();
        chk("async_rst_lit", 160'(occupancy), 160'(0));
        @(negedge clk);
        rst = 0;
        compare_all();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
